// File: rtl/adc_spi_resp_if.sv
// SPI pins between the A2D master and the emulated ADC128S-style responder.
// The bus is point-to-point, so MISO is always driven (no tristate).
interface adc_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit ADC128S converter. It returns the
// channel addressed in the previous frame, with values taken from ch_data.
//
// state | meaning
// IDLE  | waiting for SS_n fall, MISO held low
// LOAD  | one clk: capture addressed channel into tx shifter
// SHIFT | clocking command in / data out on SCLK edges
module adc_spi_resp #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    adc_spi_resp_if.slave spi,
    input  logic [95:0]   ch_data,
    output logic          cmd_vld,
    output logic [2:0]    cmd_chnl,
    output logic          frm_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("adc_spi_resp: SYNC_STAGES must be 2 or 3");
    end

    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   ss_hist_q;
    logic                   sclk_hist_q;

    logic [1:0]  state_q,    state_d;
    logic [15:0] tx_q,       tx_d;
    logic [13:0] rx_q,       rx_d;
    logic [4:0]  bit_cnt_q,  bit_cnt_d;
    logic [2:0]  chnl_q,     chnl_d;
    logic        vld_q,      vld_d;
    logic        err_q,      err_d;
    logic        miso_q,     miso_d;

    logic        ss_s, sclk_s, mosi_s;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [13:0] rx_next;
    logic [11:0] ch_arr [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_hist_q   <= 1'b1;
            sclk_hist_q <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.SS_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
            ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_fall   = ss_hist_q & ~ss_s;
    assign ss_rise   = ~ss_hist_q & ss_s;
    assign sclk_rise = ~sclk_hist_q & sclk_s;
    assign sclk_fall = sclk_hist_q & ~sclk_s;

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            ch_arr[n] = ch_data[n*12 +: 12];
        end
    end

    // Only 14 command bits are kept; the top two are don't-care and would
    // have shifted out of the address field by the end of the frame anyway.
    assign rx_next = {rx_q[12:0], mosi_s};

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        chnl_d    = chnl_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) state_d = LOAD;
            end
            LOAD: begin
                tx_d      = {4'b0000, ch_arr[chnl_q]};
                bit_cnt_d = 5'd0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (ss_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d      = rx_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        chnl_d  = rx_next[13:11];
                        vld_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (sclk_fall && bit_cnt_q != 5'd0) begin
                    tx_d = {tx_q[14:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MISO is registered so it never glitches while the shifter updates.
    assign miso_d = (state_q == SHIFT) ? tx_q[15] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            chnl_q    <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            chnl_q    <= chnl_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            miso_q    <= miso_d;
        end
    end

    assign spi.MISO = miso_q;
    assign cmd_vld  = vld_q;
    assign cmd_chnl = chnl_q;
    assign frm_err  = err_q;

endmodule

// File: tb/tb_adc_spi_resp.sv
// Directed bench for adc_spi_resp: an SPI master model drives frames while a
// scoreboard predicts each response from the previously addressed channel.
module tb_adc_spi_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] ch_data;
    logic        cmd_vld;
    logic        frm_err;
    logic [2:0]  cmd_chnl;

    adc_spi_resp_if spi ();

    adc_spi_resp #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi      (spi),
        .ch_data  (ch_data),
        .cmd_vld  (cmd_vld),
        .cmd_chnl (cmd_chnl),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    logic vld_prev = 1'b0;
    logic err_prev = 1'b0;

    logic [15:0] exp_rd_q [$];
    logic [2:0]  exp_ch_q [$];
    logic [2:0]  model_chnl = 3'd0;
    logic [11:0] lft, rght, batt;
    logic [15:0] rd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts cmd_vld/frm_err and checks they are single-cycle and exclusive.
    always @(negedge clk) begin
        if (cmd_vld || frm_err) begin
            chk("pulse_shape",
                {15'd0, (cmd_vld & frm_err) | (cmd_vld & vld_prev) | (frm_err & err_prev)},
                16'd0);
        end
        if (cmd_vld) vld_cnt++;
        if (frm_err) err_cnt++;
        vld_prev = cmd_vld;
        err_prev = frm_err;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input logic [11:0] v);
        ch_data[ch*12 +: 12] = v;
    endtask

    // One SPI frame. n_rise < 16 aborts early; rst_bit > 0 resets the DUT after that rise;
    // mod_bit > 0 rewrites channel mod_ch to mod_val mid-frame.
    task automatic frame(input logic [15:0] cmd, input int n_rise, input int mod_bit,
                         input int mod_ch, input logic [11:0] mod_val, input int rst_bit,
                         output logic [15:0] rd_o);
        logic [15:0] rdv;
        logic [15:0] exp_rd;
        logic [2:0]  exp_ch;
        int v0, e0;
        rdv = 16'd0;
        v0  = vld_cnt;
        e0  = err_cnt;
        exp_rd_q.push_back({4'h0, ch_data[int'(model_chnl)*12 +: 12]});
        if (rst_bit != 0)     model_chnl = 3'd0;
        else if (n_rise == 16) model_chnl = cmd[13:11];
        exp_ch_q.push_back(model_chnl);

        @(negedge clk);
        spi.SS_n = 1'b0;
        spi.MOSI = cmd[15];
        wait_clk(32);
        for (int i = 0; i < n_rise; i++) begin
            rdv[4'(15 - i)] = spi.MISO;
            spi.SCLK = 1'b1;
            if (rst_bit == i + 1) begin
                rst = 1'b1;
                wait_clk(1);
                chk("rst_miso", {15'd0, spi.MISO}, 16'd0);
                spi.SS_n = 1'b1;
                spi.SCLK = 1'b0;
                wait_clk(4);
                rst = 1'b0;
                wait_clk(12);
                break;
            end
            wait_clk(8);
            if (mod_bit == i + 1) set_ch(mod_ch, mod_val);
            spi.SCLK = 1'b0;
            if (i < 15) spi.MOSI = cmd[4'(14 - i)];
            wait_clk(8);
        end
        spi.SS_n = 1'b1;
        spi.MOSI = 1'b0;
        wait_clk(10);

        exp_rd = exp_rd_q.pop_front();
        exp_ch = exp_ch_q.pop_front();
        if (rst_bit != 0) begin
            chk("rst_no_vld", 16'(vld_cnt - v0), 16'd0);
            chk("rst_no_err", 16'(err_cnt - e0), 16'd0);
        end else if (n_rise == 16) begin
            chk("rd_data", rdv, exp_rd);
            chk("vld_pulses", 16'(vld_cnt - v0), 16'd1);
            chk("err_pulses", 16'(err_cnt - e0), 16'd0);
        end else begin
            chk("abort_err", 16'(err_cnt - e0), 16'd1);
            chk("abort_no_vld", 16'(vld_cnt - v0), 16'd0);
        end
        chk("cmd_chnl", {13'd0, cmd_chnl}, {13'd0, exp_ch});
        rd_o = rdv;
    endtask

    initial begin
        logic [2:0] ret_ch;
        rst      = 1'b1;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b0;
        spi.MOSI = 1'b0;
        ch_data  = '0;
        set_ch(0, 12'h0A5);
        wait_clk(5);
        chk("reset_miso", {15'd0, spi.MISO}, 16'd0);
        chk("reset_vld", {15'd0, cmd_vld}, 16'd0);
        chk("reset_err", {15'd0, frm_err}, 16'd0);
        chk("reset_chnl", {13'd0, cmd_chnl}, 16'd0);
        rst = 1'b0;
        wait_clk(5);

        // First frame after reset serves channel 0.
        frame(16'h0000, 16, 0, 0, 12'h0, 0, rd);
        chk("first_frame", rd, 16'h00A5);

        // Address channel 5 twice: response lags one frame.
        set_ch(5, 12'hABC);
        frame(16'h2800, 16, 0, 0, 12'h0, 0, rd);
        frame(16'h2800, 16, 0, 0, 12'h0, 0, rd);
        chk("ch5_frame", rd, 16'h0ABC);

        // Segway-style round robin: lft=ch0, rght=ch4, batt=ch5.
        set_ch(0, 12'h001); set_ch(4, 12'h005); set_ch(5, 12'h015);
        for (int r = 0; r < 4; r++) begin
            if (r == 2) begin
                set_ch(0, 12'h018); set_ch(4, 12'h0FF); set_ch(5, 12'h123);
            end
            for (int k = 0; k < 3; k++) begin
                ret_ch = model_chnl;
                case (k)
                    0:       frame(16'h0000, 16, 0, 0, 12'h0, 0, rd);
                    1:       frame(16'h2000, 16, 0, 0, 12'h0, 0, rd);
                    default: frame(16'h2800, 16, 0, 0, 12'h0, 0, rd);
                endcase
                if (ret_ch == 3'd0) lft  = rd[11:0];
                if (ret_ch == 3'd4) rght = rd[11:0];
                if (ret_ch == 3'd5) batt = rd[11:0];
            end
        end
        chk("segway_lft",  {4'h0, lft},  16'h0018);
        chk("segway_rght", {4'h0, rght}, 16'h00FF);
        chk("segway_batt", {4'h0, batt}, 16'h0123);

        // ch_data changes mid-frame only affect the next frame.
        frame(16'h1800, 16, 0, 0, 12'h0, 0, rd);
        set_ch(3, 12'h111);
        frame(16'h1800, 16, 4, 3, 12'h222, 0, rd);
        chk("midchange_cur", rd, 16'h0111);
        frame(16'h1800, 16, 0, 0, 12'h0, 0, rd);
        chk("midchange_next", rd, 16'h0222);

        // Abort after 9 rises: frm_err, address kept at 3.
        set_ch(7, 12'hFFF);
        frame(16'h3800, 9, 0, 0, 12'h0, 0, rd);
        frame(16'h3800, 16, 0, 0, 12'h0, 0, rd);
        chk("after_abort", rd, 16'h0222);

        // Reset at bit 7 while serving ch7, then a frame serves ch0 again.
        frame(16'h3800, 16, 0, 0, 12'h0, 7, rd);
        frame(16'h0000, 16, 0, 0, 12'h0, 0, rd);
        chk("after_reset", rd, 16'h0018);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
